mem_access_master: RTL



---
 rtl/arc_mem_pkg.sv | 27 ++
 rtl/mem_wait_counter.sv | 38 +++
 rtl/mem_access_master.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arc_mem_pkg.sv
// Shared types and constants for the ARC main-memory initiator.
// Holds the FSM state encoding, width defaults, alignment mask and latency bounds.
package arc_mem_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;
    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } mem_state_e;

    // Out-of-range latencies are pulled into the supported window.
    function automatic int unsigned clamp_latency(input int unsigned lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the memory read latency.
// done_o flags the decrement edge on which the count reaches zero.
module mem_wait_counter
    import arc_mem_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = dec_i && (cnt_q == W'(1));

endmodule

// File: rtl/mem_access_master.sv
// Main-memory initiator for the ARC datapath: one request at a time,
// drives rd/wr strobes, waits out read latency, returns data or error.
module mem_access_master
    import arc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned LAT = clamp_latency(MEM_LATENCY);

    mem_state_e        state_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_in_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic              cnt_done;
    logic              misaligned;

    assign misaligned = (ALIGN_CHECK != 0) && ((req_addr[1:0] & ALIGN_MASK) != 2'b00);

    mem_wait_counter #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == ST_READ),
        .value_i (CNT_W'(LAT)),
        .dec_i   (state_q == ST_WAIT),
        .done_o  (cnt_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        mem_address_q <= req_addr;
                        mem_data_in_q <= req_wdata;
                        if (misaligned) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (req_we) begin
                            mem_wr_q <= 1'b1;
                            state_q  <= ST_WRITE;
                        end else begin
                            mem_rd_q <= 1'b1;
                            state_q  <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    mem_wr_q     <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_READ: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_done) begin
                        resp_rdata_q <= mem_data_out;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;

endmodule
